reg_select_encoder: RTL and testbench

- Inverse of the register write-select decoder: collapses 8 per-register request lines into a 3-bit register index plus valid.
- Used by the control unit to service register-file requests one at a time, e.g. write-back or debug read-out.
- Latches pulsed requests as pending, arbitrates round-robin, and presents one index at a time on a valid/ack handshake.

---
 rtl/reg_select_encoder.sv | 122 ++++++++++++
 tb/tb_reg_select_encoder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_select_encoder.sv
// Collapses per-register request lines into one granted index at a time, presented on a valid/ack handshake.
// Optional build macro REG_SELECT_FIXED_PRIORITY_EN selects lowest-index-wins instead of round-robin.
module reg_select_encoder #(
  parameter int SEL_W     = 3,
  parameter int RESET_PTR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2**SEL_W-1:0]   req,
  input  logic                  enable,
  output logic [SEL_W-1:0]      code_out,
  output logic                  code_valid,
  input  logic                  code_ack,
  output logic [2**SEL_W-1:0]   pending
);

  localparam int N = 2**SEL_W;

  // Handshake: code_out is held stable while code_valid is high; the grant
  // completes on the edge where code_valid & code_ack; ack without valid is ignored.
  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [SEL_W-1:0] code_out_q, code_out_d;
  logic             code_valid_q, code_valid_d;
  logic [N-1:0]     clr;
  logic [SEL_W-1:0] pick;
  logic             found;

`ifndef REG_SELECT_FIXED_PRIORITY_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] scan_idx;
`endif

  // Arbitration looks only at registered pending; same-cycle req waits a cycle.
  always_comb begin
    pick  = '0;
    found = 1'b0;
`ifdef REG_SELECT_FIXED_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        pick  = SEL_W'(i);
        found = 1'b1;
      end
    end
`else
    scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = ptr_q + SEL_W'(i);
      if (!found && pending_q[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    clr = '0;
    if (code_valid_q && code_ack) clr[code_out_q] = 1'b1;
    // A set in the same cycle as the clear keeps the bit pending.
    pending_d = (pending_q & ~clr) | req;
  end

  always_comb begin
    state_d      = state_q;
    code_out_d   = code_out_q;
    code_valid_d = code_valid_q;
`ifndef REG_SELECT_FIXED_PRIORITY_EN
    ptr_d        = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        code_valid_d = 1'b0;
        if (enable && found) begin
          code_out_d   = pick;
          code_valid_d = 1'b1;
          state_d      = PRESENT;
        end
      end
      PRESENT: begin
        if (code_ack) begin
          code_valid_d = 1'b0;
          state_d      = IDLE;
`ifndef REG_SELECT_FIXED_PRIORITY_EN
          ptr_d        = code_out_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d      = IDLE;
        code_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      code_out_q   <= '0;
      code_valid_q <= 1'b0;
`ifndef REG_SELECT_FIXED_PRIORITY_EN
      ptr_q        <= SEL_W'(RESET_PTR);
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      code_out_q   <= code_out_d;
      code_valid_q <= code_valid_d;
`ifndef REG_SELECT_FIXED_PRIORITY_EN
      ptr_q        <= ptr_d;
`endif
    end
  end

  assign code_out   = code_out_q;
  assign code_valid = code_valid_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_reg_select_encoder.sv
// Self-checking bench for reg_select_encoder: directed scenarios plus randomized traffic
// compared against a behavioural model of the pending/arbitration rules.
module tb_reg_select_encoder;

  localparam int SEL_W     = 3;
  localparam int N         = 8;
  localparam int RESET_PTR = 0;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic             enable = 1'b0;
  logic [SEL_W-1:0] code_out;
  logic             code_valid;
  logic             code_ack = 1'b0;
  logic [N-1:0]     pending;

  int errors = 0;
  int checks = 0;

  reg_select_encoder #(.SEL_W(SEL_W), .RESET_PTR(RESET_PTR)) dut (
    .clk(clk), .reset(reset), .req(req), .enable(enable),
    .code_out(code_out), .code_valid(code_valid), .code_ack(code_ack),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Reference model: the set of outstanding requests, a fairness pointer,
  // and the currently presented grant (if any).
  typedef struct {
    logic [N-1:0] pend;
    int           ptr;
    logic         valid;
    int           code;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic [N-1:0] r, logic en, logic ack);
    model_t nx = cur;
    if (cur.valid && ack) nx.pend[cur.code] = 1'b0;
    nx.pend = nx.pend | r;
    if (!cur.valid) begin
      if (en && cur.pend != 0) begin
        for (int k = 0; k < N; k++) begin
`ifdef REG_SELECT_FIXED_PRIORITY_EN
          int idx = k;
`else
          int idx = (cur.ptr + k) % N;
`endif
          if (!nx.valid && cur.pend[idx]) begin
            nx.valid = 1'b1;
            nx.code  = idx;
          end
        end
      end
    end else if (ack) begin
      nx.ptr   = (cur.code + 1) % N;
      nx.valid = 1'b0;
    end
    return nx;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{pend: '0, ptr: RESET_PTR, valid: 1'b0, code: 0};
    else       m <= model_next(m, req, enable, code_ack);
  end

  logic [SEL_W-1:0] exp_q[$];
  logic [SEL_W-1:0] got_q[$];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; enable = 1'b0; code_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pending, code_valid, code_out} !== {8'h00, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: pending=%h valid=%b code=%0d, want 00/0/0", pending, code_valid, code_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    enable = 1'b1; req = 8'h04;
    tick();
    req = '0;
    checks++;
    if (pending !== 8'h04 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pending=%h valid=%b, want 04/0", pending, code_valid);
    end
    tick();
    checks++;
    if (code_valid !== 1'b1 || code_out !== 3'd2) begin
      errors++;
      $display("FAIL single_grant: valid=%b code=%0d, want 1/2", code_valid, code_out);
    end
    for (int i = 0; i < 5; i++) begin
      req = 8'h10;
      tick();
      req = '0;
      checks++;
      if (code_valid !== 1'b1 || code_out !== 3'd2) begin
        errors++;
        $display("FAIL single_hold%0d: valid=%b code=%0d, want 1/2", i, code_valid, code_out);
      end
    end
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    checks++;
    if (pending !== 8'h10 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: pending=%h valid=%b, want 10/0", pending, code_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    exp_q = '{3'd0, 3'd7, 3'd0};
    got_q.delete();
    enable = 1'b1; code_ack = 1'b1; req = 8'h81;
    for (int t = 1; t <= 8; t++) begin
      tick();
      req = (t == 3) ? 8'h01 : 8'h00;
      if (code_valid) got_q.push_back(code_out);
    end
    code_ack = 1'b0;
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL wrap_seq: got %p, want %p", got_q, exp_q);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
`ifdef REG_SELECT_FIXED_PRIORITY_EN
      exp_q.push_back(3'd0);
`else
      exp_q.push_back(SEL_W'(i % N));
`endif
    end
    enable = 1'b1; code_ack = 1'b1; req = 8'hFF;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (code_valid) got_q.push_back(code_out);
      checks++;
      if ({pending, code_valid, code_out} !== {m.pend, m.valid, SEL_W'(m.code)}) begin
        errors++;
        $display("FAIL fair_model t=%0d: dut %h/%b/%0d model %h/%b/%0d", t, pending, code_valid, code_out, m.pend, m.valid, m.code);
      end
    end
    req = '0; code_ack = 1'b0;
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL fair_seq: got %p, want %p", got_q, exp_q);
    end
  endtask

  task automatic test_collision();
    do_reset();
    enable = 1'b1; req = 8'h08;
    tick();
    req = '0;
    tick();
    checks++;
    if (code_valid !== 1'b1 || code_out !== 3'd3) begin
      errors++;
      $display("FAIL coll_grant: valid=%b code=%0d, want 1/3", code_valid, code_out);
    end
    code_ack = 1'b1; req = 8'h28;
    tick();
    req = '0;
    checks++;
    if (pending !== 8'h28 || code_valid !== 1'b0) begin
      errors++;
      $display("FAIL coll_setwins: pending=%h valid=%b, want 28/0", pending, code_valid);
    end
`ifdef REG_SELECT_FIXED_PRIORITY_EN
    exp_q = '{3'd3, 3'd5};
`else
    exp_q = '{3'd5, 3'd3};
`endif
    got_q.delete();
    for (int t = 0; t < 6; t++) begin
      tick();
      if (code_valid) got_q.push_back(code_out);
    end
    code_ack = 1'b0;
    checks++;
    if (got_q != exp_q || pending !== 8'h00) begin
      errors++;
      $display("FAIL coll_regrant: got %p pending=%h, want %p/00", got_q, pending, exp_q);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; req = 8'h12;
    tick();
    req = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (code_valid !== 1'b0 || pending !== 8'h12) begin
        errors++;
        $display("FAIL en_block%0d: valid=%b pending=%h, want 0/12", i, code_valid, pending);
      end
    end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (code_valid !== 1'b1 || code_out !== 3'd1) begin
        errors++;
        $display("FAIL en_hold%0d: valid=%b code=%0d, want 1/1", i, code_valid, code_out);
      end
    end
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
    tick();
    checks++;
    if (code_valid !== 1'b0 || pending !== 8'h10) begin
      errors++;
      $display("FAIL en_after: valid=%b pending=%h, want 0/10", code_valid, pending);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1; req = 8'h20;
    tick();
    req = 8'h04;
    tick();
    req = '0;
    checks++;
    if (code_valid !== 1'b1 || code_out !== 3'd5 || pending !== 8'h24) begin
      errors++;
      $display("FAIL ar_pre: valid=%b code=%0d pending=%h, want 1/5/24", code_valid, code_out, pending);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pending, code_valid, code_out} !== {8'h00, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL ar_immediate: pending=%h valid=%b code=%0d, want 00/0/0", pending, code_valid, code_out);
    end
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; code_ack = 1'b1;
    tick();
    tick();
    code_ack = 1'b0;
    checks++;
    if ({pending, code_valid, code_out} !== {8'h00, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL ar_spurious_ack: pending=%h valid=%b code=%0d, want 00/0/0", pending, code_valid, code_out);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      req      = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 255)) : '0;
      enable   = ($urandom_range(0, 3) != 0);
      code_ack = ($urandom_range(0, 1) == 1);
      tick();
      checks++;
      if ({pending, code_valid, code_out} !== {m.pend, m.valid, SEL_W'(m.code)}) begin
        errors++;
        $display("FAIL rand_model t=%0d: dut %h/%b/%0d model %h/%b/%0d", t, pending, code_valid, code_out, m.pend, m.valid, m.code);
      end
    end
    req = '0; enable = 1'b0; code_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_collision();
    test_enable();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
